// File: rtl/dbus_wait_bridge_pkg.sv
// ----------------------------------------------------------------------------
// dbus_wait_bridge_pkg
// Shared definitions for the data-bus wait-state bridge:
//   - FSM state encoding (IDLE / REQ / DONE)
//   - default timeout length and the data returned on an aborted read
// ----------------------------------------------------------------------------
package dbus_wait_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 32'd255;
   localparam logic [31:0] ERR_READ_VALUE_DEFAULT = 32'h0000_0000;

endpackage : dbus_wait_bridge_pkg

// File: rtl/dbus_wait_bridge_timeout_counter.sv
// ----------------------------------------------------------------------------
// bus_timeout_counter
// Counts cycles spent waiting for a downstream acknowledge.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   clr_i  - restart the count at zero (takes priority over en_i)
//   en_i   - advance the count by one
//   tc_o   - count has reached TERMINAL-1
// Only instantiated when BUS_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module bus_timeout_counter #(
   parameter int unsigned TERMINAL = 32'd255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   // Largest value ever held is TERMINAL-1, so clog2(TERMINAL) bits suffice.
   localparam int unsigned      CW   = (TERMINAL > 32'd1) ? $clog2(TERMINAL) : 32'd1;
   localparam logic [CW-1:0]    LAST = CW'(TERMINAL - 32'd1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, otherwise increment while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CW'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == LAST);

endmodule : bus_timeout_counter

// File: rtl/dbus_wait_bridge.sv
// ----------------------------------------------------------------------------
// dbus_wait_bridge
// Turns the single-cycle CPU data-bus access into a level-held req/ack
// transaction toward slow memory / MMIO, stalling the CPU until it completes.
//
// Ports:
//   iCLK, iRST            - clock, synchronous active-high reset
//   iDw*                  - CPU data-bus side (read/write enable, byte enable,
//                           address, write data); oDwReadData returns loads
//   oStall                - CPU must hold PC and bus outputs this cycle
//   oMReq/oMWe/oMBe/
//   oMAddr/oMWData        - downstream request, held constant while oMReq=1
//   iMAck, iMRData        - downstream one-cycle completion and read data
//   oBusError             - one-cycle pulse when a request is aborted
//
// Optional feature macro: BUS_TIMEOUT_EN
//   When defined, a request that sees no ack for TIMEOUT_CYCLES cycles is
//   aborted (reads return ERR_READ_VALUE, oBusError pulses). When undefined,
//   REQ waits forever and oBusError is constant 0.
// ----------------------------------------------------------------------------
module dbus_wait_bridge
   import dbus_wait_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter logic [31:0] ERR_READ_VALUE = ERR_READ_VALUE_DEFAULT
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iDwReadEnable,
   input  logic        iDwWriteEnable,
   input  logic [3:0]  iDwByteEnable,
   input  logic [31:0] iDwAddress,
   input  logic [31:0] iDwWriteData,
   output logic [31:0] oDwReadData,
   output logic        oStall,
   output logic        oMReq,
   output logic        oMWe,
   output logic [3:0]  oMBe,
   output logic [31:0] oMAddr,
   output logic [31:0] oMWData,
   input  logic        iMAck,
   input  logic [31:0] iMRData,
   output logic        oBusError
);

   state_e      state_q,  state_d;
   logic [31:0] maddr_q,  maddr_d;
   logic        mwe_q,    mwe_d;
   logic [3:0]  mbe_q,    mbe_d;
   logic [31:0] mwdata_q, mwdata_d;
   logic [31:0] rdata_q,  rdata_d;
   logic        berr_q,   berr_d;
   logic        start_s;
   logic        stall_s;
   logic        timeout_s;

   assign start_s = iDwReadEnable | iDwWriteEnable;

`ifdef BUS_TIMEOUT_EN
   logic tc_s;

   bus_timeout_counter #(
      .TERMINAL (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i (iCLK),
      .rst_i (iRST),
      .clr_i ((state_q == ST_IDLE) && start_s),
      .en_i  (state_q == ST_REQ),
      .tc_o  (tc_s)
   );

   assign timeout_s = tc_s;
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state, captured request fields, returned data and error pulse.
   always_comb begin
      state_d  = state_q;
      maddr_d  = maddr_q;
      mwe_d    = mwe_q;
      mbe_d    = mbe_q;
      mwdata_d = mwdata_q;
      rdata_d  = rdata_q;
      berr_d   = 1'b0;
      stall_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               // Stall in the very cycle the access appears; write wins over read.
               stall_s  = 1'b1;
               state_d  = ST_REQ;
               maddr_d  = iDwAddress;
               mwe_d    = iDwWriteEnable;
               mbe_d    = iDwWriteEnable ? iDwByteEnable : 4'b1111;
               mwdata_d = iDwWriteData;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_REQ: begin
            stall_s = 1'b1;
            if (iMAck) begin
               // Ack beats a coinciding timeout.
               state_d = ST_DONE;
               if (!mwe_q) begin
                  rdata_d = iMRData;
               end else begin
                  rdata_d = rdata_q;
               end
            end else if (timeout_s) begin
               state_d = ST_DONE;
               berr_d  = 1'b1;
               if (!mwe_q) begin
                  rdata_d = ERR_READ_VALUE;
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_DONE: begin
            // CPU commits on this edge; a new access is only seen next cycle.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q  <= ST_IDLE;
         maddr_q  <= 32'h0000_0000;
         mwe_q    <= 1'b0;
         mbe_q    <= 4'b0000;
         mwdata_q <= 32'h0000_0000;
         rdata_q  <= 32'h0000_0000;
         berr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         maddr_q  <= maddr_d;
         mwe_q    <= mwe_d;
         mbe_q    <= mbe_d;
         mwdata_q <= mwdata_d;
         rdata_q  <= rdata_d;
         berr_q   <= berr_d;
      end
   end

   assign oStall      = stall_s;
   assign oMReq       = (state_q == ST_REQ);
   assign oMWe        = mwe_q;
   assign oMBe        = mbe_q;
   assign oMAddr      = maddr_q;
   assign oMWData     = mwdata_q;
   assign oDwReadData = rdata_q;
   assign oBusError   = berr_q;

endmodule : dbus_wait_bridge

// File: tb/tb_dbus_wait_bridge.sv
// ----------------------------------------------------------------------------
// tb_dbus_wait_bridge
// Self-checking bench for dbus_wait_bridge. Each access is described at the
// transaction level (kind, fields, ack delay); the expected bus fields, stall
// length and returned data come from that description.
// ----------------------------------------------------------------------------
module tb_dbus_wait_bridge;

   localparam logic [31:0] ERR_VAL = 32'h0000_0000;
   localparam int          TO_CYC  = 4;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic        iDwReadEnable, iDwWriteEnable;
   logic [3:0]  iDwByteEnable;
   logic [31:0] iDwAddress, iDwWriteData;
   logic [31:0] oDwReadData;
   logic        oStall, oMReq, oMWe;
   logic [3:0]  oMBe;
   logic [31:0] oMAddr, oMWData;
   logic        iMAck;
   logic [31:0] iMRData;
   logic        oBusError;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_rdata = 32'h0;

   dbus_wait_bridge #(
      .TIMEOUT_CYCLES (TO_CYC),
      .ERR_READ_VALUE (ERR_VAL)
   ) dut (
      .iCLK           (iCLK),
      .iRST           (iRST),
      .iDwReadEnable  (iDwReadEnable),
      .iDwWriteEnable (iDwWriteEnable),
      .iDwByteEnable  (iDwByteEnable),
      .iDwAddress     (iDwAddress),
      .iDwWriteData   (iDwWriteData),
      .oDwReadData    (oDwReadData),
      .oStall         (oStall),
      .oMReq          (oMReq),
      .oMWe           (oMWe),
      .oMBe           (oMBe),
      .oMAddr         (oMAddr),
      .oMWData        (oMWData),
      .iMAck          (iMAck),
      .iMRData        (iMRData),
      .oBusError      (oBusError)
   );

   always #5 iCLK = ~iCLK;

   // One complete CPU access; ack arrives in REQ cycle number 'delay' (0-based).
   task automatic do_access(input logic re, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int delay, input logic [31:0] rd, input string nm);
      logic [3:0] ebe;
      int         stalls;
      ebe    = we ? be : 4'b1111;
      stalls = 0;
      iDwReadEnable = re; iDwWriteEnable = we; iDwByteEnable = be;
      iDwAddress = addr; iDwWriteData = wd;
      @(negedge iCLK);
      n_vec++;
      if ({oStall, oMReq} !== 2'b10) begin
         n_err++;
         $display("FAIL %s detect: stall/req=%b expected 10", nm, {oStall, oMReq});
      end
      stalls += int'(oStall);
      @(posedge iCLK); #1;
      for (int j = 0; j <= delay; j++) begin
         iMAck   = (j == delay);
         iMRData = (j == delay) ? rd : $urandom;
         @(negedge iCLK);
         n_vec++;
         if ({oMReq, oStall, oMWe, oMBe, oMAddr, oMWData, oBusError} !==
             {1'b1, 1'b1, we, ebe, addr, wd, 1'b0}) begin
            n_err++;
            $display("FAIL %s req[%0d]: got req=%b stall=%b we=%b be=%h a=%h d=%h err=%b expected 1 1 %b %h %h %h 0",
                     nm, j, oMReq, oStall, oMWe, oMBe, oMAddr, oMWData, oBusError, we, ebe, addr, wd);
         end
         stalls += int'(oStall);
         @(posedge iCLK); #1;
         iMAck = 1'b0;
      end
      if (re && !we) exp_rdata = rd;
      @(negedge iCLK);
      n_vec++;
      if ({oStall, oMReq, oBusError, oDwReadData} !== {3'b000, exp_rdata}) begin
         n_err++;
         $display("FAIL %s done: stall=%b req=%b err=%b rdata=%h expected 0 0 0 %h",
                  nm, oStall, oMReq, oBusError, oDwReadData, exp_rdata);
      end
      n_vec++;
      if (stalls != delay + 2) begin
         n_err++;
         $display("FAIL %s stall_len: got %0d expected %0d", nm, stalls, delay + 2);
      end
      @(posedge iCLK); #1;
      iDwReadEnable = 1'b0; iDwWriteEnable = 1'b0;
   endtask

   task automatic test_reset;
      iRST = 1'b1;
      iMAck = 1'b1; iMRData = $urandom;
      repeat (2) @(posedge iCLK);
      #1;
      iMAck = 1'b0;
      @(negedge iCLK);
      n_vec++;
      if ({oStall, oMReq, oMWe, oMBe, oMAddr, oMWData, oDwReadData, oBusError} !== 104'h0) begin
         n_err++;
         $display("FAIL reset: stall=%b req=%b we=%b be=%h a=%h d=%h rd=%h err=%b expected all zero",
                  oStall, oMReq, oMWe, oMBe, oMAddr, oMWData, oDwReadData, oBusError);
      end
      exp_rdata = 32'h0;
      @(posedge iCLK); #1;
      iRST = 1'b0;
   endtask

   task automatic test_read_immediate;
      do_access(1'b1, 1'b0, 4'b0000, 32'h1001_0004, 32'h0, 0, 32'hCAFE_F00D, "read_imm");
   endtask

   task automatic test_store_byte;
      do_access(1'b0, 1'b1, 4'b0100, 32'h1001_0008, 32'h00AB_0000, 2, $urandom, "store_byte");
   endtask

   task automatic test_both_enables;
      do_access(1'b1, 1'b1, 4'b0011, 32'h2000_0010, 32'h0000_BEEF, 1, $urandom, "both_en");
   endtask

   task automatic test_back_to_back;
      do_access(1'b1, 1'b0, 4'b0000, 32'h3000_0000, 32'h0, 0, 32'h1111_2222, "b2b_0");
      do_access(1'b0, 1'b1, 4'b1111, 32'h3000_0004, 32'h3333_4444, 0, $urandom, "b2b_1");
      do_access(1'b1, 1'b0, 4'b0000, 32'h3000_0008, 32'h0, 1, 32'h5555_6666, "b2b_2");
   endtask

   task automatic test_idle_ack_ignored;
      iMAck = 1'b1; iMRData = 32'hDEAD_BEEF;
      @(negedge iCLK);
      @(posedge iCLK); #1;
      iMAck = 1'b0;
      @(negedge iCLK);
      n_vec++;
      if ({oStall, oMReq, oDwReadData} !== {2'b00, exp_rdata}) begin
         n_err++;
         $display("FAIL idle_ack: stall=%b req=%b rdata=%h expected 0 0 %h", oStall, oMReq, oDwReadData, exp_rdata);
      end
      @(posedge iCLK); #1;
   endtask

   task automatic test_random;
      int          kind, gap;
      logic        re, we;
      for (int t = 0; t < 30; t++) begin
         kind = $urandom_range(0, 2);
         re   = (kind != 1);
         we   = (kind != 0);
         do_access(re, we, 4'($urandom), $urandom, $urandom, $urandom_range(0, 4), $urandom, "random");
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(negedge iCLK);
            n_vec++;
            if ({oStall, oMReq, oDwReadData} !== {2'b00, exp_rdata}) begin
               n_err++;
               $display("FAIL random_idle: stall=%b req=%b rdata=%h expected 0 0 %h", oStall, oMReq, oDwReadData, exp_rdata);
            end
            @(posedge iCLK); #1;
         end
      end
   endtask

   task automatic test_timeout;
      iDwReadEnable = 1'b1; iDwWriteEnable = 1'b0; iDwAddress = 32'h4000_0000; iDwWriteData = 32'h0;
      iMAck = 1'b0;
      @(posedge iCLK); #1;
`ifdef BUS_TIMEOUT_EN
      for (int j = 0; j < TO_CYC; j++) begin
         @(negedge iCLK);
         n_vec++;
         if ({oMReq, oStall, oBusError} !== 3'b110) begin
            n_err++;
            $display("FAIL timeout req[%0d]: req/stall/err=%b expected 110", j, {oMReq, oStall, oBusError});
         end
         @(posedge iCLK); #1;
      end
      exp_rdata = ERR_VAL;
      @(negedge iCLK);
      n_vec++;
      if ({oStall, oMReq, oBusError, oDwReadData} !== {3'b001, exp_rdata}) begin
         n_err++;
         $display("FAIL timeout done: stall=%b req=%b err=%b rdata=%h expected 0 0 1 %h",
                  oStall, oMReq, oBusError, oDwReadData, exp_rdata);
      end
      @(posedge iCLK); #1;
      iDwReadEnable = 1'b0;
      @(negedge iCLK);
      n_vec++;
      if (oBusError !== 1'b0) begin
         n_err++;
         $display("FAIL timeout pulse_len: err=%b expected 0", oBusError);
      end
      @(posedge iCLK); #1;
`else
      for (int j = 0; j < 4 * TO_CYC; j++) begin
         @(negedge iCLK);
         n_vec++;
         if ({oMReq, oStall, oBusError} !== 3'b110) begin
            n_err++;
            $display("FAIL no_timeout req[%0d]: req/stall/err=%b expected 110", j, {oMReq, oStall, oBusError});
         end
         @(posedge iCLK); #1;
      end
      iMAck = 1'b1; iMRData = 32'h7777_8888;
      @(posedge iCLK); #1;
      iMAck = 1'b0;
      exp_rdata = 32'h7777_8888;
      @(negedge iCLK);
      n_vec++;
      if ({oStall, oMReq, oBusError, oDwReadData} !== {3'b000, exp_rdata}) begin
         n_err++;
         $display("FAIL no_timeout done: stall=%b req=%b err=%b rdata=%h expected 0 0 0 %h",
                  oStall, oMReq, oBusError, oDwReadData, exp_rdata);
      end
      @(posedge iCLK); #1;
      iDwReadEnable = 1'b0;
`endif
   endtask

   task automatic test_reset_mid_req;
      iDwReadEnable = 1'b1; iDwWriteEnable = 1'b0; iDwAddress = 32'h5000_00F0; iDwByteEnable = 4'b1010;
      iDwWriteData = 32'h1234_5678;
      @(posedge iCLK); #1;
      @(negedge iCLK);
      n_vec++;
      if (oMReq !== 1'b1) begin
         n_err++;
         $display("FAIL mid_reset req1: req=%b expected 1", oMReq);
      end
      @(posedge iCLK); #1;
      iRST = 1'b1; iDwReadEnable = 1'b0;
      @(posedge iCLK); #1;
      iRST = 1'b0;
      exp_rdata = 32'h0;
      iMAck = 1'b1; iMRData = 32'hFFFF_0000;
      @(negedge iCLK);
      n_vec++;
      if ({oStall, oMReq, oMWe, oMBe, oMAddr, oMWData, oDwReadData, oBusError} !== 104'h0) begin
         n_err++;
         $display("FAIL mid_reset after: stall=%b req=%b we=%b be=%h a=%h d=%h rd=%h err=%b expected all zero",
                  oStall, oMReq, oMWe, oMBe, oMAddr, oMWData, oDwReadData, oBusError);
      end
      @(posedge iCLK); #1;
      iMAck = 1'b0;
      @(negedge iCLK);
      n_vec++;
      if ({oStall, oMReq, oDwReadData} !== 34'h0) begin
         n_err++;
         $display("FAIL mid_reset stray_ack: stall=%b req=%b rdata=%h expected 0 0 0", oStall, oMReq, oDwReadData);
      end
      @(posedge iCLK); #1;
      do_access(1'b1, 1'b0, 4'b0000, 32'h5000_0000, 32'h0, 1, 32'hA5A5_5A5A, "post_reset");
   endtask

   initial begin
      iRST = 1'b1;
      iDwReadEnable = 1'b0; iDwWriteEnable = 1'b0; iDwByteEnable = 4'b0000;
      iDwAddress = 32'h0; iDwWriteData = 32'h0;
      iMAck = 1'b0; iMRData = 32'h0;
      test_reset;
      test_read_immediate;
      test_store_byte;
      test_both_enables;
      test_back_to_back;
      test_idle_ack_ignored;
      test_random;
      test_timeout;
      test_reset_mid_req;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_dbus_wait_bridge
